// File: rtl/sdram_rw_arbiter_if.sv
// rtl/sdram_rw_arbiter_if.sv - arbiter <-> SDRAM state controller request/ack bus
// Purpose: groups the burst request/ack handshake and the burst base address.
// Ports (signals):
//   wr_req, rd_req  burst write/read request (arbiter -> controller)
//   sys_addr        burst base word address (arbiter -> controller)
//   sdram_wr_ack    controller write-data window (controller -> arbiter)
//   sdram_rd_ack    controller read-data window (controller -> arbiter)
// Modports: master = arbiter side, slave = controller side.
interface sdram_rw_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] sys_addr;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;

    modport master (
        output wr_req, rd_req, sys_addr,
        input  sdram_wr_ack, sdram_rd_ack
    );

    modport slave (
        input  wr_req, rd_req, sys_addr,
        output sdram_wr_ack, sdram_rd_ack
    );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// rtl/sdram_rw_arbiter.sv - SDRAM read/write burst arbiter over a circular burst buffer
// Purpose: shares one SDRAM port between the write-FIFO capture path and the
//   read-FIFO readout path, one fixed-length burst per request, with write/read
//   burst pointers, occupancy and full/empty tracking.
// Optional feature macro: SDRAM_ARB_WDOG_EN enables the ack watchdog (arb_err).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sdram_init_done     SDRAM initialisation complete
//   wr_fifo_level       words present in write FIFO
//   rd_fifo_space       free words in read FIFO
//   rd_en               readout enabled
//   ctrl (master)       wr_req/rd_req/sys_addr out, sdram_wr_ack/sdram_rd_ack in
//   wr_fifo_re          write-FIFO read strobe
//   rd_fifo_we          read-FIFO write strobe
//   occupancy           bursts stored
//   sdram_full/empty    buffer status
//   arb_err             sticky watchdog error
module sdram_rw_arbiter #(
    parameter int BURST_W    = 8,
    parameter int PTR_W      = 14,
    parameter int LVL_W      = 10,
    parameter int HIGH_WATER = 768,
    parameter int WDOG_CYC   = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sdram_init_done,
    input  logic [LVL_W-1:0]      wr_fifo_level,
    input  logic [LVL_W-1:0]      rd_fifo_space,
    input  logic                  rd_en,
    sdram_rw_arbiter_if.master    ctrl,
    output logic                  wr_fifo_re,
    output logic                  rd_fifo_we,
    output logic [PTR_W:0]        occupancy,
    output logic                  sdram_full,
    output logic                  sdram_empty,
    output logic                  arb_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_XFER,
        RD_REQ,
        RD_XFER,
        GAP
    } state_t;

    localparam logic [LVL_W:0] BURST_WORDS = (LVL_W+1)'(1 << BURST_W);
    localparam logic [LVL_W:0] HW_LEVEL    = (LVL_W+1)'(HIGH_WATER);
    localparam logic [PTR_W:0] DEPTH       = {1'b1, {PTR_W{1'b0}}};

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             last_wr;
    logic             wr_ok;
    logic             rd_ok;
    logic             grant_wr;
    logic             grant_rd;
    logic             wdog_hit;

    assign sdram_full  = (occupancy == DEPTH);
    assign sdram_empty = (occupancy == '0);

    assign wr_ok = sdram_init_done && !sdram_full
                   && ({1'b0, wr_fifo_level} >= BURST_WORDS);
    assign rd_ok = sdram_init_done && rd_en && !sdram_empty
                   && ({1'b0, rd_fifo_space} >= BURST_WORDS);

    // High-water writes pre-empt fairness; otherwise ties alternate on last_wr.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_ok && ({1'b0, wr_fifo_level} >= HW_LEVEL)) begin
            grant_wr = 1'b1;
        end else if (wr_ok && rd_ok) begin
            grant_wr = !last_wr;
            grant_rd = last_wr;
        end else if (wr_ok) begin
            grant_wr = 1'b1;
        end else if (rd_ok) begin
            grant_rd = 1'b1;
        end
    end

    // Strobes follow the controller's data window with zero latency.
    assign wr_fifo_re = ctrl.sdram_wr_ack && (state == WR_REQ || state == WR_XFER);
    assign rd_fifo_we = ctrl.sdram_rd_ack && (state == RD_REQ || state == RD_XFER);

`ifdef SDRAM_ARB_WDOG_EN
    logic [9:0] wdog_cnt;
    logic       busy;
    logic       leaving;

    assign busy    = (state == WR_REQ) || (state == WR_XFER)
                     || (state == RD_REQ) || (state == RD_XFER);
    assign leaving = (state == WR_REQ  &&  ctrl.sdram_wr_ack)
                     || (state == WR_XFER && !ctrl.sdram_wr_ack)
                     || (state == RD_REQ  &&  ctrl.sdram_rd_ack)
                     || (state == RD_XFER && !ctrl.sdram_rd_ack);
    // Counter holds the number of cycles already spent in the current state.
    assign wdog_hit = busy && (wdog_cnt == 10'(WDOG_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (busy && !leaving && !wdog_hit) begin
            wdog_cnt <= wdog_cnt + 10'd1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ctrl.wr_req   <= 1'b0;
            ctrl.rd_req   <= 1'b0;
            ctrl.sys_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            last_wr       <= 1'b0;
            arb_err       <= 1'b0;
        end else if (wdog_hit) begin
            // Abandon the burst without touching pointers or occupancy.
            ctrl.wr_req <= 1'b0;
            ctrl.rd_req <= 1'b0;
            arb_err     <= 1'b1;
            state       <= GAP;
        end else begin
            case (state)
                IDLE: begin
                    ctrl.sys_addr <= {wr_ptr, {BURST_W{1'b0}}};
                    if (grant_wr) begin
                        ctrl.wr_req <= 1'b1;
                        state       <= WR_REQ;
                    end else if (grant_rd) begin
                        ctrl.rd_req   <= 1'b1;
                        ctrl.sys_addr <= {rd_ptr, {BURST_W{1'b0}}};
                        state         <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (ctrl.sdram_wr_ack) begin
                        ctrl.wr_req <= 1'b0;
                        state       <= WR_XFER;
                    end
                end
                // XFER is entered with ack high, so any low ack here is its falling edge.
                WR_XFER: begin
                    if (!ctrl.sdram_wr_ack) begin
                        wr_ptr    <= wr_ptr + PTR_W'(1);
                        occupancy <= occupancy + (PTR_W+1)'(1);
                        last_wr   <= 1'b1;
                        state     <= GAP;
                    end
                end
                RD_REQ: begin
                    if (ctrl.sdram_rd_ack) begin
                        ctrl.rd_req <= 1'b0;
                        state       <= RD_XFER;
                    end
                end
                // A short (stopped) read burst still retires a whole burst slot.
                RD_XFER: begin
                    if (!ctrl.sdram_rd_ack) begin
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        occupancy <= occupancy - (PTR_W+1)'(1);
                        last_wr   <= 1'b0;
                        state     <= GAP;
                    end
                end
                // One idle cycle lets the controller return to idle before a new request.
                GAP: begin
                    ctrl.sys_addr <= {wr_ptr, {BURST_W{1'b0}}};
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_rw_arbiter.md
# sdram_rw_arbiter

Shares the single SDRAM read/write port between the event-capture write path (write FIFO → SDRAM) and the readout path (SDRAM → read FIFO). The arbiter runs the SDRAM as a circular buffer of fixed-length bursts. It issues one wr_req/rd_req per burst to the SDRAM state controller and supplies the burst base address. It tracks write/read pointers, burst occupancy and full/empty status, and gates FIFO strobes from the controller's acks.

## Interface
- BURST_W, 8: log2 of burst length in 16-bit words; burst = 256 words
- PTR_W, 14: burst pointer width; buffer depth = 2^PTR_W bursts
- LVL_W, 10: FIFO level/space port width
- HIGH_WATER, 768: write-FIFO level at which writes gain absolute priority
- WDOG_CYC, 1023: ack watchdog limit in clk cycles
- clk  in  1  system clock (53 MHz SDRAM domain)
- rst_n  in  1  asynchronous, active-low reset
- sdram_init_done  in  1  SDRAM initialisation complete
- wr_fifo_level  in  LVL_W  words present in write FIFO
- rd_fifo_space  in  LVL_W  free words in read FIFO
- rd_en  in  1  readout enabled
- sdram_wr_ack  in  1  controller write-data window
- sdram_rd_ack  in  1  controller read-data window
- wr_req  out  1  burst write request to controller
- rd_req  out  1  burst read request to controller
- sys_addr  out  PTR_W+BURST_W  burst base word address {ptr, BURST_W'b0}
- wr_fifo_re  out  1  write-FIFO read strobe
- rd_fifo_we  out  1  read-FIFO write strobe
- occupancy  out  PTR_W+1  bursts stored
- sdram_full  out  1  occupancy == 2^PTR_W
- sdram_empty  out  1  occupancy == 0
- arb_err  out  1  sticky watchdog error

## Operation
- States: IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER, GAP.
- wr_ok = init_done & !sdram_full & wr_fifo_level >= 2^BURST_W.
- rd_ok = init_done & rd_en & !sdram_empty & rd_fifo_space >= 2^BURST_W.
- IDLE: if wr_ok & wr_fifo_level >= HIGH_WATER → WR_REQ. Else if wr_ok & rd_ok → grant the side not granted last (last_wr flag; reset value 0, so write wins first tie). Else the single eligible side. Else stay.
- WR_REQ: wr_req=1, sys_addr={wr_ptr,0}; on sdram_wr_ack=1 → WR_XFER, wr_req drops in same cycle as transition (registered low next cycle).
- WR_XFER: wait for sdram_wr_ack falling (1→0) → wr_ptr+1 (wraps mod 2^PTR_W), occupancy+1, last_wr=1 → GAP.
- RD_REQ/RD_XFER: same, with rd_req, sdram_rd_ack, rd_ptr, occupancy−1, last_wr=0.
- GAP: one cycle, no request; → IDLE. Guarantees controller returns to idle before next request is seen.
- wr_fifo_re = sdram_wr_ack & (state ∈ {WR_REQ, WR_XFER}); rd_fifo_we = sdram_rd_ack & (state ∈ {RD_REQ, RD_XFER}). Combinational, zero latency.
- sys_addr holds the granted pointer from REQ entry until GAP; in IDLE it shows wr_ptr.
- Only one transfer in flight, so pointer/occupancy never update simultaneously.
- Short read burst (controller rd_bstop) still counts as a full burst.

## Timing
- Reset: state IDLE, wr_req=0, rd_req=0, wr_ptr=rd_ptr=0, occupancy=0, sdram_empty=1, sdram_full=0, arb_err=0, sys_addr=0, last_wr=0. Strobes 0.
- IDLE decision registered: wr_req/rd_req high 1 cycle after eligibility is sampled.
- Request held until first ack cycle; deasserted on the following edge.
- occupancy/full/empty update 1 cycle after ack falling edge detected; next request earliest 2 cycles after ack falls (GAP + IDLE).
- Full: wr_ok=0, write requests blocked; reads continue. Empty: reads blocked.
- Pointer wrap: 2^PTR_W−1 → 0; occupancy compared, not pointers.
- init_done low: no new grant; an in-flight burst completes.
- rst_n assert mid-burst: immediate return to reset values; stored data is discarded.

## Configuration
- SDRAM_ARB_WDOG_EN defined: 10-bit counter runs in WR_REQ/RD_REQ/WR_XFER/RD_XFER and clears on state change. On reaching WDOG_CYC it sets arb_err (sticky until reset), drops the request and goes to GAP. Pointers and occupancy are not updated.
- Undefined: no counter, REQ/XFER wait indefinitely, arb_err tied 0.

## Test plan
- Reset, init_done=1, wr_fifo_level=256, rd_en=0, controller model acks 256 cycles → one wr_req, 256 wr_fifo_re pulses, sys_addr=0, occupancy=1, sdram_empty=0.
- 3 bursts stored, wr_fifo_level=300, rd_fifo_space=512, rd_en=1 → grants alternate W,R,W,R starting with R (last_wr=1); sys_addr tracks {ptr,8'h00}.
- wr_fifo_level=800 with read also eligible and last_wr=1 → write granted (high-water priority).
- PTR_W=2: write 4 bursts → sdram_full=1, no further wr_req; read 1 → full=0, rd_ptr=1; 5th write uses address 0 (wrap).
- Assert rst_n low during WR_XFER at word 100 → all outputs at reset values next cycle; occupancy=0.
- SDRAM_ARB_WDOG_EN defined, no ack after wr_req → arb_err=1 after 1023 cycles, wr_req=0, occupancy unchanged.
